// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared definitions for the instruction-fetch stage: default reset PC,
//   instruction size, FSM state encoding and the canonical NOP word.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifu_out_reg.sv
// ifu_out_reg
//   One-entry valid/ready pipeline register carrying {pc, inst, misalign}
//   toward decode.
//   Ports:
//     clock, reset     : clock and synchronous active-high reset
//     load             : capture in_* this cycle (caller guarantees space)
//     flush            : drop any buffered entry; wins over load and transfer
//     in_pc/in_inst/in_misalign : entry being captured
//     out_ready        : downstream accepts the presented entry
//     out_valid/out_pc/out_inst/out_misalign : presented entry
module ifu_out_reg
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  input  logic            in_misalign,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_misalign
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    if (flush) begin
      // Data fields are left as-is; only validity matters after a flush.
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = in_pc;
      inst_d     = in_inst;
      misalign_d = in_misalign;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_inst     = inst_q;
  assign out_misalign = misalign_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction-fetch stage. Owns the architectural PC, addresses a
//   combinational ROM, and registers {pc, inst} into a one-entry output
//   stage toward decode. Supports redirect/flush, halt and a fetch counter.
//   Ports:
//     clock, reset            : clock and synchronous active-high reset
//     rom_addr / rom_inst     : ROM address (= pc register) and returned word
//     out_valid/out_ready     : decode handshake
//     out_pc/out_inst/out_misalign : presented instruction
//     redirect_valid/redirect_target : flush and new PC
//     halt_req / halted       : stop request and HALT-state indication
//     fetch_count             : instructions loaded into the output stage
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_misalign,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            load;
  logic            flush;

  // Output stage has room when empty or when its entry leaves this cycle.
  assign load  = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                 (!out_valid || out_ready);
  // Halt also drops a buffered entry: the halting instruction has committed.
  assign flush = redirect_valid || halt_req;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;

    if (state_q == ST_RUN && halt_req) begin
      state_d = ST_HALT;
    end

    // Redirect updates pc in either state; only RUN can advance it.
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (load) begin
      pc_d = pc_q + XLEN'(INST_BYTES);
    end

    if (load) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifu_out_reg #(
    .XLEN(XLEN)
  ) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .in_pc       (pc_q),
    .in_inst     (rom_inst),
    .in_misalign (pc_q[1:0] != 2'b00),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_misalign(out_misalign)
  );

  assign rom_addr    = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
//   Directed bench for ifu_fetch. The ROM model returns addr ^ 32'h1234_5678.
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign rom_inst = rom_addr ^ 32'h1234_5678;

  ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misalign   (out_misalign),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // One line per accepted transfer.
  always @(posedge clock) begin
    if (!reset && out_valid && out_ready)
      $display("xfer pc=%08h inst=%08h mis=%0b", out_pc, out_inst, out_misalign);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $display("FAIL %s: observed %08h expected %08h", name, obs, exp);
      $error("check %s", name);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] pc,
                           input logic mis, input logic [31:0] cnt);
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".pc"}, out_pc, pc);
    check({name, ".inst"}, out_inst, pc ^ 32'h1234_5678);
    check({name, ".mis"}, {31'd0, out_misalign}, {31'd0, mis});
    check({name, ".cnt"}, fetch_count, cnt);
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    halt_req = 1'b0;
    #1;

    // 1. Reset then run
    step();
    step();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.pc", out_pc, 32'h0);
    check("rst.inst", out_inst, 32'h0);
    check("rst.mis", {31'd0, out_misalign}, 32'd0);
    check("rst.cnt", fetch_count, 32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    check("run.addr0", rom_addr, 32'h8000_0000);
    step();
    check("run.inst0", out_inst, 32'h9234_5678);
    check_out("run0", 32'h8000_0000, 1'b0, 32'd1);
    step();
    check_out("run1", 32'h8000_0004, 1'b0, 32'd2);
    step();
    check_out("run2", 32'h8000_0008, 1'b0, 32'd3);
    check("run.addr3", rom_addr, 32'h8000_000C);

    // 2. Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("bp", 32'h8000_0008, 1'b0, 32'd3);
      check("bp.addr", rom_addr, 32'h8000_000C);
    end
    out_ready = 1'b1;
    step();
    check_out("bp.rel", 32'h8000_000C, 1'b0, 32'd4);
    check("bp.addr_rel", rom_addr, 32'h8000_0010);

    // 3. Redirect with a stalled entry
    step();
    check_out("rd.pre", 32'h8000_0010, 1'b0, 32'd5);
    out_ready = 1'b0;
    step();
    check_out("rd.stall", 32'h8000_0010, 1'b0, 32'd5);
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    check("rd.valid0", {31'd0, out_valid}, 32'd0);
    check("rd.addr", rom_addr, 32'h8000_0100);
    check("rd.cnt", fetch_count, 32'd5);
    step();
    check_out("rd.tgt", 32'h8000_0100, 1'b0, 32'd6);

    // 4. Misaligned redirect
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    check("mis.valid0", {31'd0, out_valid}, 32'd0);
    check("mis.addr", rom_addr, 32'h8000_0102);
    step();
    check("mis.inst", out_inst, 32'h9234_577A);
    check_out("mis0", 32'h8000_0102, 1'b1, 32'd7);
    step();
    check_out("mis1", 32'h8000_0106, 1'b1, 32'd8);

    // 6. PC and counter wrap
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap.addr", rom_addr, 32'hFFFF_FFFC);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    check("wrap.precnt", fetch_count, 32'hFFFF_FFFF);
    step();
    check("wrap.inst", out_inst, 32'hEDCB_A984);
    check_out("wrap0", 32'hFFFF_FFFC, 1'b0, 32'd0);
    check("wrap.addr0", rom_addr, 32'h0000_0000);
    step();
    check_out("wrap1", 32'h0000_0000, 1'b0, 32'd1);

    // 5. Halt with simultaneous redirect
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0200;
    step();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    check("halt.halted", {31'd0, halted}, 32'd1);
    check("halt.valid", {31'd0, out_valid}, 32'd0);
    check("halt.addr", rom_addr, 32'h8000_0200);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt.hold_valid", {31'd0, out_valid}, 32'd0);
      check("halt.hold_addr", rom_addr, 32'h8000_0200);
      check("halt.hold_cnt", fetch_count, 32'd1);
      check("halt.hold_halted", {31'd0, halted}, 32'd1);
    end
    // Redirect while halted moves pc but never presents anything.
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    check("halt.rd_addr", rom_addr, 32'h8000_0300);
    step();
    check("halt.rd_valid", {31'd0, out_valid}, 32'd0);

    // Reset leaves HALT
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2.halted", {31'd0, halted}, 32'd0);
    check("rst2.addr", rom_addr, 32'h8000_0000);
    check("rst2.cnt", fetch_count, 32'd0);
    step();
    check_out("rst2.run", 32'h8000_0000, 1'b0, 32'd1);

    // Halt alone drops a stalled entry and freezes pc
    out_ready = 1'b0;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt2.valid", {31'd0, out_valid}, 32'd0);
    check("halt2.halted", {31'd0, halted}, 32'd1);
    check("halt2.addr", rom_addr, 32'h8000_0004);
    out_ready = 1'b1;
    step();
    check("halt2.addr_hold", rom_addr, 32'h8000_0004);
    check("halt2.cnt", fetch_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
